// File: rtl/wb_lsu_pkg.sv
// Shared types for the Wishbone load/store master: access sizes, FSM states
// and the byte-lane count of the 32-bit data path.
package wb_lsu_pkg;

  localparam int unsigned NLANES = 4;

  typedef enum logic [1:0] {
    SZ_BYTE    = 2'd0,
    SZ_HALF    = 2'd1,
    SZ_WORD    = 2'd2,
    SZ_INVALID = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_e;

endpackage

// File: rtl/wb_lane_align.sv
// Byte-lane steering: store-side select/replication/misalign detection and
// load-side lane extraction with sign or zero extension.
module wb_lane_align
  import wb_lsu_pkg::*;
(
  input  logic [1:0]        i_st_lo,
  input  size_e             i_st_size,
  input  logic [31:0]       i_st_wdata,
  output logic [NLANES-1:0] o_sel,
  output logic              o_misalign,
  output logic [31:0]       o_st_data,
  input  logic [1:0]        i_ld_lo,
  input  size_e             i_ld_size,
  input  logic              i_ld_unsigned,
  input  logic [31:0]       i_ld_data,
  output logic [31:0]       o_ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    o_sel      = '0;
    o_misalign = 1'b0;
    o_st_data  = '0;
    case (i_st_size)
      SZ_BYTE: begin
        o_sel     = 4'b0001 << i_st_lo;
        o_st_data = {4{i_st_wdata[7:0]}};
      end
      SZ_HALF: begin
        o_sel      = i_st_lo[1] ? 4'b1100 : 4'b0011;
        o_st_data  = {2{i_st_wdata[15:0]}};
        o_misalign = i_st_lo[0];
      end
      SZ_WORD: begin
        o_sel      = 4'b1111;
        o_st_data  = i_st_wdata;
        o_misalign = |i_st_lo;
      end
      default: o_misalign = 1'b1;
    endcase
  end

  always_comb begin
    ld_byte = i_ld_data[7:0];
    case (i_ld_lo)
      2'd0: ld_byte = i_ld_data[7:0];
      2'd1: ld_byte = i_ld_data[15:8];
      2'd2: ld_byte = i_ld_data[23:16];
      2'd3: ld_byte = i_ld_data[31:24];
      default: ld_byte = i_ld_data[7:0];
    endcase
    ld_half = i_ld_lo[1] ? i_ld_data[31:16] : i_ld_data[15:0];
    case (i_ld_size)
      SZ_BYTE: o_ld_data = {{24{~i_ld_unsigned & ld_byte[7]}}, ld_byte};
      SZ_HALF: o_ld_data = {{16{~i_ld_unsigned & ld_half[15]}}, ld_half};
      default: o_ld_data = i_ld_data;
    endcase
  end

endmodule

// File: rtl/wb_lsu_master.sv
// Single-outstanding Wishbone pipelined initiator turning CPU load/store
// requests into bus cycles, with misalign, bus-error and timeout reporting.
module wb_lsu_master
  import wb_lsu_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned AW        = XLEN - 2,
  parameter int unsigned LGTIMEOUT = 10
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [XLEN-1:0]   i_req_addr,
  input  logic [1:0]        i_req_size,
  input  logic              i_req_unsigned,
  input  logic [XLEN-1:0]   i_req_wdata,
  output logic              o_rsp_valid,
  output logic              o_rsp_err,
  output logic [XLEN-1:0]   o_rsp_rdata,
  output logic              o_wb_cyc,
  output logic              o_wb_stb,
  output logic              o_wb_we,
  output logic [AW-1:0]     o_wb_addr,
  output logic [XLEN-1:0]   o_wb_data,
  output logic [XLEN/8-1:0] o_wb_sel,
  input  logic              i_wb_stall,
  input  logic              i_wb_ack,
  input  logic              i_wb_err,
  input  logic [XLEN-1:0]   i_wb_data
);

  localparam logic [LGTIMEOUT-1:0] T_ONE  = 1;
  // Last count before the abort; the cycle count starts at zero on accept.
  localparam logic [LGTIMEOUT-1:0] T_LAST = {{(LGTIMEOUT-1){1'b1}}, 1'b0};

  state_e               state;
  logic [LGTIMEOUT-1:0] tcount;
  logic [1:0]           r_lo;
  size_e                r_size;
  logic                 r_unsigned;

  logic [NLANES-1:0]    a_sel;
  logic                 a_misalign;
  logic [XLEN-1:0]      a_st_data;
  logic [XLEN-1:0]      a_ld_data;
  logic                 bus_live;
  logic                 tmo;

  assign o_req_ready = (state == S_IDLE) && !i_reset;

  // A stalled strobe has not been taken by the slave, so any ack/err then is not ours.
  assign bus_live = (state == S_WAIT) || ((state == S_REQ) && !i_wb_stall);
  assign tmo      = (tcount == T_LAST);

  wb_lane_align u_align (
    .i_st_lo       (i_req_addr[1:0]),
    .i_st_size     (size_e'(i_req_size)),
    .i_st_wdata    (i_req_wdata),
    .o_sel         (a_sel),
    .o_misalign    (a_misalign),
    .o_st_data     (a_st_data),
    .i_ld_lo       (r_lo),
    .i_ld_size     (r_size),
    .i_ld_unsigned (r_unsigned),
    .i_ld_data     (i_wb_data),
    .o_ld_data     (a_ld_data)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state       <= S_IDLE;
      tcount      <= '0;
      r_lo        <= '0;
      r_size      <= SZ_BYTE;
      r_unsigned  <= 1'b0;
      o_wb_cyc    <= 1'b0;
      o_wb_stb    <= 1'b0;
      o_wb_we     <= 1'b0;
      o_wb_addr   <= '0;
      o_wb_data   <= '0;
      o_wb_sel    <= '0;
      o_rsp_valid <= 1'b0;
      o_rsp_err   <= 1'b0;
      o_rsp_rdata <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          o_rsp_valid <= 1'b0;
          if (i_req_valid) begin
            tcount     <= '0;
            r_lo       <= i_req_addr[1:0];
            r_size     <= size_e'(i_req_size);
            r_unsigned <= i_req_unsigned;
            if (a_misalign) begin
              o_rsp_valid <= 1'b1;
              o_rsp_err   <= 1'b1;
              o_rsp_rdata <= '0;
              state       <= S_RESP;
            end else begin
              o_wb_cyc  <= 1'b1;
              o_wb_stb  <= 1'b1;
              o_wb_we   <= i_req_we;
              o_wb_addr <= i_req_addr[XLEN-1:2];
              o_wb_sel  <= a_sel;
              o_wb_data <= a_st_data;
              state     <= S_REQ;
            end
          end
        end
        S_REQ, S_WAIT: begin
          tcount <= tcount + T_ONE;
          if (bus_live && i_wb_err) begin
            o_wb_cyc    <= 1'b0;
            o_wb_stb    <= 1'b0;
            o_rsp_valid <= 1'b1;
            o_rsp_err   <= 1'b1;
            o_rsp_rdata <= '0;
            state       <= S_RESP;
          end else if (bus_live && i_wb_ack) begin
            o_wb_cyc    <= 1'b0;
            o_wb_stb    <= 1'b0;
            o_rsp_valid <= 1'b1;
            o_rsp_err   <= 1'b0;
            o_rsp_rdata <= o_wb_we ? '0 : a_ld_data;
            state       <= S_RESP;
          end else if (tmo) begin
            o_wb_cyc    <= 1'b0;
            o_wb_stb    <= 1'b0;
            o_rsp_valid <= 1'b1;
            o_rsp_err   <= 1'b1;
            o_rsp_rdata <= '0;
            state       <= S_RESP;
          end else if ((state == S_REQ) && !i_wb_stall) begin
            o_wb_stb <= 1'b0;
            state    <= S_WAIT;
          end
        end
        S_RESP: begin
          o_rsp_valid <= 1'b0;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_lsu_master.sv
// Directed bench for wb_lsu_master with a small block-RAM slave model.
module tb_wb_lsu_master;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        i_req_valid, o_req_ready, i_req_we, i_req_unsigned;
  logic [31:0] i_req_addr, i_req_wdata;
  logic [1:0]  i_req_size;
  logic        o_rsp_valid, o_rsp_err;
  logic [31:0] o_rsp_rdata;
  logic        o_wb_cyc, o_wb_stb, o_wb_we;
  logic [29:0] o_wb_addr;
  logic [31:0] o_wb_data;
  logic [3:0]  o_wb_sel;
  logic        i_wb_stall, i_wb_ack, i_wb_err;
  logic [31:0] i_wb_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wb_lsu_master #(.XLEN(32), .AW(30), .LGTIMEOUT(4)) dut (
    .i_clk(clk), .i_reset(i_reset),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_we(i_req_we),
    .i_req_addr(i_req_addr), .i_req_size(i_req_size), .i_req_unsigned(i_req_unsigned),
    .i_req_wdata(i_req_wdata),
    .o_rsp_valid(o_rsp_valid), .o_rsp_err(o_rsp_err), .o_rsp_rdata(o_rsp_rdata),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we), .o_wb_addr(o_wb_addr),
    .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel),
    .i_wb_stall(i_wb_stall), .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err), .i_wb_data(i_wb_data)
  );

  // Slave: decides stall/ack on the falling edge, acks the cycle after an accepted strobe.
  logic [31:0] mem [0:255];
  logic        pend = 1'b0;
  logic        p_we;
  logic [29:0] p_addr;
  logic [31:0] p_data;
  logic [3:0]  p_sel;
  int          stall_left = 0;
  int          stray_cnt  = 0;
  logic        slv_mute   = 1'b0;
  logic        slv_err    = 1'b0;

  always @(negedge clk) begin
    i_wb_ack   = 1'b0;
    i_wb_err   = 1'b0;
    i_wb_data  = '0;
    i_wb_stall = 1'b0;
    if (o_wb_stb && !o_wb_cyc) begin
      bad++;
      $display("FAIL stb_without_cyc: stb=%b cyc=%b required cyc=1", o_wb_stb, o_wb_cyc);
    end
    if (pend) begin
      pend = 1'b0;
      if (!slv_mute) begin
        if (slv_err) i_wb_err = 1'b1;
        else begin
          i_wb_ack = 1'b1;
          if (p_we) begin
            for (int k = 0; k < 4; k++)
              if (p_sel[k]) mem[p_addr[7:0]][8*k +: 8] = p_data[8*k +: 8];
          end else i_wb_data = mem[p_addr[7:0]];
        end
      end
    end
    if (stray_cnt > 0) begin
      i_wb_ack = 1'b1;
      i_wb_err = 1'b1;
      stray_cnt--;
    end
    if (o_wb_stb) begin
      if (stall_left > 0) begin
        i_wb_stall = 1'b1;
        stall_left--;
      end else begin
        pend   = 1'b1;
        p_we   = o_wb_we;
        p_addr = o_wb_addr;
        p_data = o_wb_data;
        p_sel  = o_wb_sel;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic run_req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                         input logic uns, input logic [31:0] wdata,
                         output logic rdy, output int lat, output int cyc_n, output int stb_n,
                         output logic stable, output logic [3:0] sel, output logic [31:0] bdata,
                         output logic [29:0] baddr, output logic bwe,
                         output logic err, output logic [31:0] rdata);
    @(negedge clk);
    i_req_valid = 1'b1; i_req_we = we; i_req_addr = addr; i_req_size = size;
    i_req_unsigned = uns; i_req_wdata = wdata;
    #1 rdy = o_req_ready;
    @(negedge clk);
    i_req_valid = 1'b0;
    lat = 1; cyc_n = 0; stb_n = 0; stable = 1'b1;
    sel = '0; bdata = '0; baddr = '0; bwe = 1'b0;
    while (!o_rsp_valid && lat < 100) begin
      if (o_wb_cyc) cyc_n++;
      if (o_wb_stb) begin
        if (stb_n == 0) begin
          sel = o_wb_sel; bdata = o_wb_data; baddr = o_wb_addr; bwe = o_wb_we;
        end else if (sel !== o_wb_sel || bdata !== o_wb_data || baddr !== o_wb_addr || bwe !== o_wb_we)
          stable = 1'b0;
        stb_n++;
      end
      @(negedge clk);
      lat++;
    end
    err = o_rsp_err;
    rdata = o_rsp_rdata;
  endtask

  typedef struct {
    string       name;
    logic        we;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wdata;
    logic        bus;
    logic [3:0]  sel;
    logic [31:0] bdata;
    logic [29:0] baddr;
    logic        err;
    logic [31:0] rdata;
    int          lat;
  } vec_t;

  vec_t v[12];

  logic        rdy, stable, bwe, err, flag;
  int          lat, cyc_n, stb_n;
  logic [3:0]  sel;
  logic [31:0] bdata, rdata;
  logic [29:0] baddr;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    v[0]  = '{"st_b_103",  1'b1, 32'h103, 2'd0, 1'b0, 32'h0000_00AB, 1'b1, 4'b1000, 32'hABAB_ABAB, 30'h40, 1'b0, 32'h0,         3};
    v[1]  = '{"ld_sb_103", 1'b0, 32'h103, 2'd0, 1'b0, 32'h0,         1'b1, 4'b1000, 32'h0,         30'h40, 1'b0, 32'hFFFF_FFAB, 3};
    v[2]  = '{"st_h_202",  1'b1, 32'h202, 2'd1, 1'b0, 32'h0000_8001, 1'b1, 4'b1100, 32'h8001_8001, 30'h80, 1'b0, 32'h0,         3};
    v[3]  = '{"ld_uh_202", 1'b0, 32'h202, 2'd1, 1'b1, 32'h0,         1'b1, 4'b1100, 32'h0,         30'h80, 1'b0, 32'h0000_8001, 3};
    v[4]  = '{"ld_sh_202", 1'b0, 32'h202, 2'd1, 1'b0, 32'h0,         1'b1, 4'b1100, 32'h0,         30'h80, 1'b0, 32'hFFFF_8001, 3};
    v[5]  = '{"st_w_010",  1'b1, 32'h010, 2'd2, 1'b0, 32'h1234_5678, 1'b1, 4'b1111, 32'h1234_5678, 30'h04, 1'b0, 32'h0,         3};
    v[6]  = '{"ld_w_010",  1'b0, 32'h010, 2'd2, 1'b0, 32'h0,         1'b1, 4'b1111, 32'h0,         30'h04, 1'b0, 32'h1234_5678, 3};
    v[7]  = '{"ld_ub_011", 1'b0, 32'h011, 2'd0, 1'b1, 32'h0,         1'b1, 4'b0010, 32'h0,         30'h04, 1'b0, 32'h0000_0056, 3};
    v[8]  = '{"ld_sb_013", 1'b0, 32'h013, 2'd0, 1'b0, 32'h0,         1'b1, 4'b1000, 32'h0,         30'h04, 1'b0, 32'h0000_0012, 3};
    v[9]  = '{"ld_w_mis",  1'b0, 32'h002, 2'd2, 1'b0, 32'h0,         1'b0, 4'b0000, 32'h0,         30'h00, 1'b1, 32'h0,         1};
    v[10] = '{"ld_sz3",    1'b0, 32'h000, 2'd3, 1'b0, 32'h0,         1'b0, 4'b0000, 32'h0,         30'h00, 1'b1, 32'h0,         1};
    v[11] = '{"st_h_mis",  1'b1, 32'h201, 2'd1, 1'b0, 32'h0000_BEEF, 1'b0, 4'b0000, 32'h0,         30'h00, 1'b1, 32'h0,         1};

    i_reset = 1'b1; i_req_valid = 1'b0; i_req_we = 1'b0; i_req_addr = '0;
    i_req_size = '0; i_req_unsigned = 1'b0; i_req_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_cyc", 32'(o_wb_cyc), 32'd0);
    chk("rst_stb", 32'(o_wb_stb), 32'd0);
    chk("rst_sel", 32'(o_wb_sel), 32'd0);
    chk("rst_addr", 32'(o_wb_addr), 32'd0);
    chk("rst_data", o_wb_data, 32'd0);
    chk("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
    chk("rst_ready_in_reset", 32'(o_req_ready), 32'd0);
    i_reset = 1'b0;
    #1 chk("rst_ready_after", 32'(o_req_ready), 32'd1);

    for (int i = 0; i < 12; i++) begin
      run_req(v[i].we, v[i].addr, v[i].size, v[i].uns, v[i].wdata,
              rdy, lat, cyc_n, stb_n, stable, sel, bdata, baddr, bwe, err, rdata);
      chk({v[i].name, "_ready"}, 32'(rdy), 32'd1);
      chk({v[i].name, "_lat"}, 32'(lat), 32'(v[i].lat));
      chk({v[i].name, "_cyc_seen"}, 32'(cyc_n != 0), 32'(v[i].bus));
      if (v[i].bus) begin
        chk({v[i].name, "_sel"}, 32'(sel), 32'(v[i].sel));
        chk({v[i].name, "_wbaddr"}, 32'(baddr), 32'(v[i].baddr));
        chk({v[i].name, "_we"}, 32'(bwe), 32'(v[i].we));
        if (v[i].we) chk({v[i].name, "_wbdata"}, bdata, v[i].bdata);
      end
      chk({v[i].name, "_err"}, 32'(err), 32'(v[i].err));
      chk({v[i].name, "_rdata"}, rdata, v[i].rdata);
    end

    // Stalled word store: fields held for all stall cycles plus the taken one.
    stall_left = 3;
    run_req(1'b1, 32'h020, 2'd2, 1'b0, 32'hCAFE_F00D,
            rdy, lat, cyc_n, stb_n, stable, sel, bdata, baddr, bwe, err, rdata);
    chk("stall_stb_cycles", 32'(stb_n), 32'd4);
    chk("stall_stable", 32'(stable), 32'd1);
    chk("stall_data", bdata, 32'hCAFE_F00D);
    chk("stall_sel", 32'(sel), 32'hF);
    chk("stall_lat", 32'(lat), 32'd6);
    chk("stall_err", 32'(err), 32'd0);

    // Silent slave: abort after 15 cycles, then stray ack/err must be ignored.
    slv_mute = 1'b1;
    run_req(1'b0, 32'h000, 2'd2, 1'b0, 32'h0,
            rdy, lat, cyc_n, stb_n, stable, sel, bdata, baddr, bwe, err, rdata);
    chk("tmo_cyc_cycles", 32'(cyc_n), 32'd15);
    chk("tmo_lat", 32'(lat), 32'd16);
    chk("tmo_err", 32'(err), 32'd1);
    chk("tmo_rdata", rdata, 32'd0);
    stray_cnt = 3;
    flag = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (o_rsp_valid || o_wb_cyc) flag = 1'b1;
    end
    chk("stray_ack_ignored", 32'(flag), 32'd0);
    slv_mute = 1'b0;

    slv_err = 1'b1;
    run_req(1'b0, 32'h010, 2'd2, 1'b0, 32'h0,
            rdy, lat, cyc_n, stb_n, stable, sel, bdata, baddr, bwe, err, rdata);
    chk("buserr_err", 32'(err), 32'd1);
    chk("buserr_rdata", rdata, 32'd0);
    chk("buserr_lat", 32'(lat), 32'd3);
    slv_err = 1'b0;

    // Reset while waiting for the ack.
    slv_mute = 1'b1;
    @(negedge clk);
    i_req_valid = 1'b1; i_req_we = 1'b0; i_req_addr = 32'h010; i_req_size = 2'd2;
    @(negedge clk);
    i_req_valid = 1'b0;
    @(negedge clk);
    chk("rstmid_cyc_before", 32'(o_wb_cyc), 32'd1);
    i_reset = 1'b1;
    @(negedge clk);
    chk("rstmid_cyc", 32'(o_wb_cyc), 32'd0);
    chk("rstmid_stb", 32'(o_wb_stb), 32'd0);
    chk("rstmid_rsp_valid", 32'(o_rsp_valid), 32'd0);
    i_reset = 1'b0;
    #1 chk("rstmid_ready", 32'(o_req_ready), 32'd1);
    flag = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (o_rsp_valid) flag = 1'b1;
    end
    chk("rstmid_no_rsp", 32'(flag), 32'd0);
    slv_mute = 1'b0;

    run_req(1'b0, 32'h103, 2'd0, 1'b1, 32'h0,
            rdy, lat, cyc_n, stb_n, stable, sel, bdata, baddr, bwe, err, rdata);
    chk("post_rst_ld_ub", rdata, 32'h0000_00AB);
    chk("post_rst_lat", 32'(lat), 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
